// File: rtl/lsu_trigger_hit_pipe_pkg.sv
// Shared swerv_types additions for the LSU trigger hit pipeline: trigger count,
// DC4/DC5 pipe record and the pairwise chaining helper.
package swerv_types;

  localparam int unsigned LSU_TRIG_NUM = 4;

  typedef struct packed {
    logic [LSU_TRIG_NUM-1:0] match;
  } lsu_trig_pipe_t;

  // A chained pair (2k, 2k+1) only matches when both halves match.
  function automatic logic [LSU_TRIG_NUM-1:0] lsu_trig_chain(
    input logic [LSU_TRIG_NUM-1:0]   match,
    input logic [LSU_TRIG_NUM/2-1:0] chain
  );
    logic [LSU_TRIG_NUM-1:0] res;
    res = match;
    for (int unsigned k = 0; k < LSU_TRIG_NUM / 2; k++) begin
      if (chain[k]) begin
        res[2*k]   = match[2*k] & match[2*k+1];
        res[2*k+1] = match[2*k] & match[2*k+1];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_trigger_hit_pipe_cnt.sv
// Per-trigger hit counter (module lsu_trigger_cnt); only built when
// LSU_TRIGGER_COUNT_EN is defined.
`ifdef LSU_TRIGGER_COUNT_EN
module lsu_trigger_cnt #(
  parameter int unsigned COUNT_WIDTH = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic                   dec_en,
  input  logic                   freeze,
  output logic                   fire,
  output logic [COUNT_WIDTH-1:0] count
);

  // Count 0 means counting is off; count 1 is the final countdown step.
  assign fire = dec_en & (count < COUNT_WIDTH'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec_en && !freeze && (count != '0)) begin
      count <= count - COUNT_WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/lsu_trigger_hit_pipe.sv
// DC3->DC5 trigger hit pipeline with chaining, flush kill and sticky status.
// Per-trigger hit counters are present only with LSU_TRIGGER_COUNT_EN defined.
module lsu_trigger_hit_pipe
  import swerv_types::*;
#(
  parameter int unsigned COUNT_WIDTH = 14
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [LSU_TRIG_NUM-1:0]                 lsu_trigger_match_dc3,
  input  logic [LSU_TRIG_NUM/2-1:0]               trigger_chain,
  input  logic                                    dec_tlu_flush_lower_dc5,
  input  logic [LSU_TRIG_NUM-1:0]                 trigger_count_wr,
  input  logic [COUNT_WIDTH-1:0]                  trigger_count_wdata,
  input  logic [LSU_TRIG_NUM-1:0]                 trigger_status_clr,
  output logic [LSU_TRIG_NUM-1:0]                 lsu_trigger_hit_dc5,
  output logic [LSU_TRIG_NUM-1:0]                 lsu_trigger_status,
  output logic [LSU_TRIG_NUM-1:0][COUNT_WIDTH-1:0] trigger_count_rdata
);

  lsu_trig_pipe_t          dc4;
  lsu_trig_pipe_t          dc5;
  logic [LSU_TRIG_NUM-1:0] q;
  logic [LSU_TRIG_NUM-1:0] hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc4 <= '0;
      dc5 <= '0;
    end else if (dec_tlu_flush_lower_dc5) begin
      dc4 <= '0;
      dc5 <= '0;
    end else begin
      dc4.match <= lsu_trig_chain(lsu_trigger_match_dc3, trigger_chain);
      dc5       <= dc4;
    end
  end

  assign q = dc5.match & ~{LSU_TRIG_NUM{dec_tlu_flush_lower_dc5}};

`ifdef LSU_TRIGGER_COUNT_EN
  logic [LSU_TRIG_NUM-1:0] fire;

  for (genvar i = 0; i < LSU_TRIG_NUM; i++) begin : g_cnt
    // Even trigger of a chained pair defers to its odd partner's counter.
    lsu_trigger_cnt #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (trigger_count_wr[i]),
      .load_val (trigger_count_wdata),
      .dec_en   (q[i]),
      .freeze   (((i % 2) == 0) ? trigger_chain[i/2] : 1'b0),
      .fire     (fire[i]),
      .count    (trigger_count_rdata[i])
    );
  end

  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < LSU_TRIG_NUM / 2; k++) begin
      hit[2*k+1] = fire[2*k+1];
      hit[2*k]   = trigger_chain[k] ? fire[2*k+1] : fire[2*k];
    end
  end
`else
  logic unused_count_inputs;

  assign unused_count_inputs = ^{trigger_count_wr, trigger_count_wdata};
  assign hit                 = q;
  assign trigger_count_rdata = '0;
`endif

  assign lsu_trigger_hit_dc5 = hit;

  // Set wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsu_trigger_status <= '0;
    end else begin
      lsu_trigger_status <= (lsu_trigger_status & ~trigger_status_clr) | hit;
    end
  end

endmodule

// File: tb/tb_lsu_trigger_hit_pipe.sv
// Directed bench for lsu_trigger_hit_pipe; expectations adapt to LSU_TRIGGER_COUNT_EN.
module tb_lsu_trigger_hit_pipe;

  localparam int unsigned CW = 14;
`ifdef LSU_TRIGGER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic [3:0]          match;
  logic [1:0]          chain;
  logic                flush;
  logic [3:0]          cnt_wr;
  logic [CW-1:0]       cnt_wdata;
  logic [3:0]          clr;
  logic [3:0]          hit;
  logic [3:0]          status;
  logic [3:0][CW-1:0]  rdata;

  int total;
  int bad;

  lsu_trigger_hit_pipe #(
    .COUNT_WIDTH(CW)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .lsu_trigger_match_dc3   (match),
    .trigger_chain           (chain),
    .dec_tlu_flush_lower_dc5 (flush),
    .trigger_count_wr        (cnt_wr),
    .trigger_count_wdata     (cnt_wdata),
    .trigger_status_clr      (clr),
    .lsu_trigger_hit_dc5     (hit),
    .lsu_trigger_status      (status),
    .trigger_count_rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] match;
    logic [1:0] chain;
    logic       flush;
    logic [3:0] clr;
    logic [3:0] hit;
    logic [3:0] status;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic [3:0] m, logic [1:0] c, logic f,
                              logic [3:0] cl, logic [3:0] h, logic [3:0] s);
    vec_t v;
    v.match = m; v.chain = c; v.flush = f; v.clr = cl; v.hit = h; v.status = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] m, input logic [3:0] wr, input logic [CW-1:0] wd);
    match = m;
    cnt_wr = wr;
    cnt_wdata = wd;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    match = '0; chain = '0; flush = 1'b0; cnt_wr = '0; cnt_wdata = '0; clr = '0;

    //            match    chain  fl    clr      hit      status
    tbl[0]  = mk(4'b0001, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tbl[1]  = mk(4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tbl[2]  = mk(4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    tbl[3]  = mk(4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    tbl[4]  = mk(4'b0001, 2'b01, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    tbl[5]  = mk(4'b0011, 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tbl[6]  = mk(4'b0000, 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tbl[7]  = mk(4'b0000, 2'b01, 1'b0, 4'b0000, 4'b0011, 4'b0000);
    tbl[8]  = mk(4'b1000, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0011);
    tbl[9]  = mk(4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0011);
    tbl[10] = mk(4'b0000, 2'b00, 1'b1, 4'b0000, 4'b0000, 4'b0011);
    tbl[11] = mk(4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0011);
    tbl[12] = mk(4'b0100, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0011);
    tbl[13] = mk(4'b0000, 2'b00, 1'b1, 4'b0000, 4'b0000, 4'b0011);
    tbl[14] = mk(4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0011);
    tbl[15] = mk(4'b0010, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0011);
    tbl[16] = mk(4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0011);
    tbl[17] = mk(4'b0000, 2'b00, 1'b0, 4'b0010, 4'b0010, 4'b0011);
    tbl[18] = mk(4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0011);

    step();
    step();
    chk("reset_hit", 64'(hit), 64'h0);
    chk("reset_status", 64'(status), 64'h0);
    chk("reset_rdata", 64'(rdata), 64'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 19; i++) begin
      match = tbl[i].match;
      chain = tbl[i].chain;
      flush = tbl[i].flush;
      clr   = tbl[i].clr;
      #1;
      chk($sformatf("tbl%0d_hit", i), 64'(hit), 64'(tbl[i].hit));
      chk($sformatf("tbl%0d_status", i), 64'(status), 64'(tbl[i].status));
      chk($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'h0);
      step();
    end
    match = '0; chain = '0; flush = 1'b0; clr = '0;

    // Countdown on trigger 2 from 3, four back-to-back matches.
    drive(4'b0000, 4'b0100, CW'(3));
    step();
    for (int k = 0; k < 7; k++) begin
      logic [3:0]    eh;
      logic [CW-1:0] er;
      drive((k < 4) ? 4'b0100 : 4'b0000, 4'b0000, '0);
      eh = 4'b0000;
      if (k == 2 || k == 3) eh = CNT_EN ? 4'b0000 : 4'b0100;
      if (k == 4 || k == 5) eh = 4'b0100;
      er = (k <= 2) ? CW'(3) : (k == 3) ? CW'(2) : (k == 4) ? CW'(1) : CW'(0);
      if (!CNT_EN) er = '0;
      #1;
      chk($sformatf("cnt_hit_c%0d", k), 64'(hit), 64'(eh));
      chk($sformatf("cnt_rdata2_c%0d", k), 64'(rdata[2]), 64'(er));
      step();
    end

    // Load coincident with a count-1 fire on trigger 1.
    drive(4'b0000, 4'b0010, CW'(1));
    step();
    drive(4'b0010, 4'b0000, '0);
    step();
    drive(4'b0000, 4'b0000, '0);
    step();
    drive(4'b0000, 4'b0010, CW'(5));
    #1;
    chk("load_fire_hit", 64'(hit), 64'h2);
    step();
    drive(4'b0000, 4'b0000, '0);
    #1;
    chk("load_fire_rdata1", 64'(rdata[1]), CNT_EN ? 64'd5 : 64'd0);
    drive(4'b0000, 4'b1111, '0);
    step();

    // Chained pair 0/1: odd counter decides, even counter frozen.
    chain = 2'b01;
    drive(4'b0000, 4'b0010, CW'(2));
    step();
    drive(4'b0000, 4'b0001, CW'(7));
    step();
    drive(4'b0011, 4'b0000, '0);
    step();
    step();
    drive(4'b0000, 4'b0000, '0);
    #1;
    chk("chcnt_hit0", 64'(hit), CNT_EN ? 64'h0 : 64'h3);
    chk("chcnt_rdata1_0", 64'(rdata[1]), CNT_EN ? 64'd2 : 64'd0);
    step();
    chk("chcnt_hit1", 64'(hit), 64'h3);
    chk("chcnt_rdata1_1", 64'(rdata[1]), CNT_EN ? 64'd1 : 64'd0);
    step();
    chain = 2'b00;
    #1;
    chk("chcnt_rdata0", 64'(rdata[0]), CNT_EN ? 64'd7 : 64'd0);
    chk("chcnt_rdata1_2", 64'(rdata[1]), 64'd0);
    drive(4'b0000, 4'b1111, '0);
    step();

    // Asynchronous reset with DC4/DC5 full and a nonzero counter.
    drive(4'b0000, 4'b1000, CW'(4));
    step();
    drive(4'b1100, 4'b0000, '0);
    step();
    step();
    drive(4'b0000, 4'b0000, '0);
    #1;
    chk("prerst_hit", 64'(hit), CNT_EN ? 64'h4 : 64'hc);
    chk("prerst_status_nz", 64'(status != 4'b0000), 64'h1);
    rst = 1'b1;
    #1;
    chk("rst_hit", 64'(hit), 64'h0);
    chk("rst_status", 64'(status), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("postrst_hit%0d", k), 64'(hit), 64'h0);
      step();
    end
    chk("postrst_status", 64'(status), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_trigger_hit_pipe.md
# lsu_trigger_hit_pipe

Downstream companion of the LSU trigger matcher. Takes the raw per-trigger match vector produced in DC3 and carries it through DC4 and DC5. Along the way it applies trigger chaining, flush kill and per-trigger hit counting, and presents final trigger hits to the decode/TLU in DC5. It also keeps sticky per-trigger hit status bits that software can read and clear through the TLU.

## Interface
Parameters:
- COUNT_WIDTH, default 14: width of each per-trigger hit counter.

Ports:
- clk  input  1  core clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- lsu_trigger_match_dc3  input  4  raw match per trigger. Already qualified by valid, non-DMA and load/store type.
- trigger_chain  input  2  bit0 chains triggers 0/1; bit1 chains triggers 2/3.
- dec_tlu_flush_lower_dc5  input  1  kills DC4 and DC5 contents.
- trigger_count_wr  input  4  per-trigger counter load strobe.
- trigger_count_wdata  input  COUNT_WIDTH  counter load value; shared by all triggers.
- trigger_status_clr  input  4  per-trigger sticky-status clear.
- lsu_trigger_hit_dc5  output  4  final trigger hit for the DC5 instruction.
- lsu_trigger_status  output  4  sticky hit bits.
- trigger_count_rdata  output  4 x COUNT_WIDTH  current counter values.

## Operation
- Pipeline stages:
  - DC4 register holds the match vector after chaining.
  - DC5 register holds a copy of DC4.
  - Both stages advance every cycle; there is no stall.
- Chaining (applied at DC3→DC4 capture), for pair (2k, 2k+1) with trigger_chain[k]=1:
  - Both captured bits equal match[2k] & match[2k+1].
  - An unchained pair passes through unchanged.
- Flush: when dec_tlu_flush_lower_dc5=1:
  - lsu_trigger_hit_dc5 is 0 that cycle (combinational kill).
  - DC4 and DC5 load 0 on the next edge.
  - A DC3 match presented in the flush cycle is also discarded.
- Qualified match q[i]: DC5 bit i with no flush.
- Counter, per trigger:
  - Count 0 means counting is off; the trigger fires on every q[i].
  - Count ≥2: q[i] decrements the counter; no fire.
  - Count 1: q[i] fires and the counter goes to 0.
  - Chained pair: the decision uses the odd trigger's counter; the even counter is frozen. Both hit bits take the odd trigger's result.
- Counter load: trigger_count_wr[i] loads trigger_count_wdata on the next edge.
  - Load wins over a same-cycle decrement.
  - The fire decision in the load cycle uses the pre-load value.
- Sticky status: status[i] sets on lsu_trigger_hit_dc5[i] and clears on trigger_status_clr[i]. If set and clear occur in the same cycle, set wins.
- Reset values: DC4 = 0, DC5 = 0, all counters = 0, status = 0, lsu_trigger_hit_dc5 = 0.

## Timing
- Latency: a match at DC3 in cycle N appears on lsu_trigger_hit_dc5 in cycle N+2.
- lsu_trigger_hit_dc5 is combinational from the DC5 flops, the counters and the flush input. It has no other combinational input.
- lsu_trigger_status and trigger_count_rdata are pure flop outputs; updates are visible the cycle after the causing event.
- Back-to-back matches on every cycle are handled: the counter decrements once per cycle.
- Counter arithmetic is unsigned with no wrap. A counter at 0 stays at 0; it never decrements below 0.
- Reset asserted mid-operation clears all state immediately, asynchronously. The first valid hit can occur two cycles after reset deassertion.

## Configuration
- LSU_TRIGGER_COUNT_EN defined:
  - Counters are present and behave as described above.
- LSU_TRIGGER_COUNT_EN undefined:
  - No counter flops; trigger_count_wr and trigger_count_wdata are ignored.
  - trigger_count_rdata is tied to 0.
  - Every qualified match fires; chaining and flush are unchanged.

## Structure
- Shared package swerv_types additions:
  - lsu_trig_pipe_t struct, holding the 4-bit match vector; used for the DC4/DC5 registers.
  - LSU_TRIG_NUM = 4 constant.
- COUNT_WIDTH stays a module parameter.
- One sub-module, lsu_trigger_cnt, instantiated per trigger:
  - Inputs: load, load value, decrement enable, chain-freeze.
  - Outputs: fire decision and count value.
  - Entire sub-module is compiled under LSU_TRIGGER_COUNT_EN.

## Test plan
- Single match: match=4'b0001 for one cycle in N, no chain, counts 0 → hit=4'b0001 exactly in cycle N+2; status[0]=1 from N+3.
- Chain: chain=2'b01.
  - Match 4'b0001 → no hit.
  - Match 4'b0011 → hit=4'b0011 two cycles later.
- Flush:
  - Match 4'b1000 in cycle N, flush asserted in N+2 → hit=0 in N+2 and status unchanged.
  - Second case: match in N, flush in N+1 → DC5 empty in N+2, hit=0.
- Counter: load trigger 2 with 3, then apply matches 4'b0100 on 3 consecutive cycles.
  - No hit on the first two; hit on the third.
  - rdata[2] goes 3→2→1→0.
  - A fourth match fires again (count 0).
- Simultaneous events:
  - Load trigger 1 with 5 in the same cycle as a DC5 fire with count 1 → hit=1 and rdata[1]=5 next cycle.
  - Status clear coincident with a hit → status stays 1.
- Async reset mid-flight: assert rst while DC4 and DC5 hold matches and counters are nonzero → all outputs 0 immediately; no hit after deassertion without new matches.
